// File: rtl/bus_responder_pkg.sv
// Shared types and constants for the bus_responder slice: bus word, wait counter,
// FSM state encoding and the address-window decode helper.
package bus_responder_pkg;

  localparam int unsigned BUS_W   = 16;
  localparam int unsigned COUNT_W = 4;

  typedef logic [BUS_W-1:0]   bus_word_t;
  typedef logic [COUNT_W-1:0] wait_count_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    ACCESS,
    DONE
  } bus_resp_state_t;

  // Bits below addr_bits select a RAM word; everything above must match the base.
  function automatic logic window_hit(input bus_word_t addr, input bus_word_t base,
                                      input int unsigned addr_bits);
    bus_word_t mask;
    mask = '1;
    mask = mask << addr_bits;
    return ((addr ^ base) & mask) == '0;
  endfunction

endpackage

// File: rtl/bus_responder_ram.sv
// Single-port word RAM with a registered, enable-held read port; only the
// read register is reset, the array keeps its contents across reset.
module resp_ram
  import bus_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [BUS_W-1:0]     wdata,
  output logic [BUS_W-1:0]     rdata
);

  logic [BUS_W-1:0] mem [2**ADDR_BITS];
  logic [BUS_W-1:0] rdata_q;
  logic [BUS_W-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/bus_responder.sv
// Slave end of the core's ALE/nME/nOE/RnW/nWait multiplexed bus: latches and
// decodes the address, inserts wait states, then reads or writes the local RAM.
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS   = 8,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic [15:0] BusIn,
  input  logic        ALE,
  input  logic        nME,
  input  logic        nOE,
  input  logic        RnW,
  output logic [15:0] RdData,
  output logic        RdEn,
  output logic        nWait
);

  localparam wait_count_t WAIT_INIT = wait_count_t'(WAIT_STATES);
  localparam wait_count_t COUNT_ONE = wait_count_t'(1);

  bus_resp_state_t state_q, state_d;
  bus_word_t       addr_q, addr_d;
  logic            hit_q, hit_d;
  wait_count_t     count_q, count_d;
  logic            rd_valid_q, rd_valid_d;
  logic            nwait_q, nwait_d;

  logic            ram_we;
  logic            ram_re;
  logic [15:0]     ram_rdata;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    hit_d      = hit_q;
    count_d    = count_q;
    rd_valid_d = rd_valid_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;

    case (state_q)
      IDLE: begin
        if (ALE) begin
          addr_d  = BusIn;
          hit_d   = window_hit(BusIn, BASE_ADDR, ADDR_BITS);
          state_d = ADDR;
        end
      end

      // A fresh ALE always wins over a pending nME so the newest address is used.
      ADDR: begin
        if (ALE) begin
          addr_d = BusIn;
          hit_d  = window_hit(BusIn, BASE_ADDR, ADDR_BITS);
        end else if (!nME) begin
          if (!hit_q) begin
            state_d = DONE;
          end else if (WAIT_STATES == 0) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            count_d = WAIT_INIT;
          end
        end
      end

      WAIT: begin
        if (nME) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q - COUNT_ONE;
          if (count_q <= COUNT_ONE) begin
            state_d = ACCESS;
          end
        end
      end

      ACCESS: begin
        ram_re  = RnW;
        ram_we  = ~RnW;
        if (RnW) begin
          rd_valid_d = 1'b1;
        end
        state_d = DONE;
      end

      DONE: begin
        if (nME) begin
          state_d    = IDLE;
          rd_valid_d = 1'b0;
        end
      end

      default: begin
        state_d    = IDLE;
        rd_valid_d = 1'b0;
      end
    endcase

    nwait_d = (state_d != WAIT);
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      hit_q      <= 1'b0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      nwait_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      hit_q      <= hit_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      nwait_q    <= nwait_d;
    end
  end

  resp_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk  (Clock),
    .rst_n(nReset),
    .we   (ram_we),
    .re   (ram_re),
    .addr (addr_q[ADDR_BITS-1:0]),
    .wdata(BusIn),
    .rdata(ram_rdata)
  );

  assign RdData = ram_rdata;
  assign RdEn   = rd_valid_q & ~nOE & ~nME;
  assign nWait  = nwait_q;

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: one DUT with two wait states, one with none,
// sharing the bus lines but each with its own nME.
module tb_bus_responder;
  import bus_responder_pkg::*;

  logic        Clock = 1'b0;
  logic        nReset;
  logic [15:0] BusIn;
  logic        ALE;
  logic        nOE;
  logic        RnW;
  logic        nME_a;
  logic        nME_b;
  logic [15:0] RdData_a, RdData_b;
  logic        RdEn_a, RdEn_b;
  logic        nWait_a, nWait_b;

  int total = 0;
  int bad   = 0;

  always #5 Clock = ~Clock;

  bus_responder #(
    .ADDR_BITS  (8),
    .BASE_ADDR  (16'h0000),
    .WAIT_STATES(2)
  ) dut_a (
    .Clock (Clock),
    .nReset(nReset),
    .BusIn (BusIn),
    .ALE   (ALE),
    .nME   (nME_a),
    .nOE   (nOE),
    .RnW   (RnW),
    .RdData(RdData_a),
    .RdEn  (RdEn_a),
    .nWait (nWait_a)
  );

  bus_responder #(
    .ADDR_BITS  (8),
    .BASE_ADDR  (16'h0000),
    .WAIT_STATES(0)
  ) dut_b (
    .Clock (Clock),
    .nReset(nReset),
    .BusIn (BusIn),
    .ALE   (ALE),
    .nME   (nME_b),
    .nOE   (nOE),
    .RnW   (RnW),
    .RdData(RdData_b),
    .RdEn  (RdEn_b),
    .nWait (nWait_b)
  );

  task automatic set_nme(input bit sel, input logic val);
    if (sel) nME_b = val;
    else     nME_a = val;
  endtask

  // One bus cycle: an ALE cycle, then nME low for ncyc negedges (raised at abort_at).
  // Counts negedge samples with nWait low and the first sample index with RdEn high.
  task automatic do_access(input bit sel, input logic [15:0] addr, input logic rnw,
                           input logic [15:0] wdata, input logic noe, input int ncyc,
                           input int abort_at, output int wait_lows, output int first_valid);
    logic nw;
    logic re;
    @(negedge Clock);
    ALE = 1'b1; BusIn = addr; RnW = 1'b1; nOE = 1'b1;
    @(negedge Clock);
    ALE = 1'b0; BusIn = wdata; RnW = rnw; nOE = noe;
    set_nme(sel, 1'b0);
    wait_lows   = 0;
    first_valid = -1;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge Clock);
      if (abort_at == i) set_nme(sel, 1'b1);
      #1;
      nw = sel ? nWait_b : nWait_a;
      re = sel ? RdEn_b : RdEn_a;
      if (nw === 1'b0) wait_lows++;
      if (re === 1'b1 && first_valid < 0) first_valid = i;
    end
  endtask

  task automatic release_bus(input bit sel);
    @(negedge Clock);
    set_nme(sel, 1'b1);
    nOE = 1'b1;
    @(negedge Clock);
    #1;
  endtask

  task automatic test_reset;
    nReset = 1'b0;
    BusIn = 16'h0000; ALE = 1'b0; nOE = 1'b1; RnW = 1'b1;
    nME_a = 1'b1; nME_b = 1'b1;
    #12;
    total++; if (nWait_a !== 1'b1) begin bad++; $display("[TB] FAIL reset_nwait: got %b expected 1", nWait_a); end
    total++; if (RdEn_a !== 1'b0) begin bad++; $display("[TB] FAIL reset_rden: got %b expected 0", RdEn_a); end
    total++; if (RdData_a !== 16'h0000) begin bad++; $display("[TB] FAIL reset_rddata: got %h expected 0000", RdData_a); end
    total++; if (RdData_b !== 16'h0000 || nWait_b !== 1'b1) begin bad++; $display("[TB] FAIL reset_b: got %h/%b expected 0000/1", RdData_b, nWait_b); end
    @(negedge Clock);
    nReset = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_write_read;
    int wl, fv;
    do_access(1'b0, 16'h0012, 1'b0, 16'hBEEF, 1'b1, 5, 0, wl, fv);
    total++; if (wl != 2) begin bad++; $display("[TB] FAIL write_wait_cycles: got %0d expected 2", wl); end
    total++; if (fv != -1) begin bad++; $display("[TB] FAIL write_rden: got first valid %0d expected none", fv); end
    release_bus(1'b0);
    do_access(1'b0, 16'h0012, 1'b1, 16'h0000, 1'b0, 5, 0, wl, fv);
    total++; if (wl != 2) begin bad++; $display("[TB] FAIL read_wait_cycles: got %0d expected 2", wl); end
    total++; if (fv != 4) begin bad++; $display("[TB] FAIL read_latency: got %0d expected 4", fv); end
    total++; if (RdEn_a !== 1'b1) begin bad++; $display("[TB] FAIL read_rden: got %b expected 1", RdEn_a); end
    total++; if (RdData_a !== 16'hBEEF) begin bad++; $display("[TB] FAIL read_data: got %h expected beef", RdData_a); end
    release_bus(1'b0);
    total++; if (RdEn_a !== 1'b0) begin bad++; $display("[TB] FAIL release_rden: got %b expected 0", RdEn_a); end
    total++; if (dut_a.state_q !== IDLE) begin bad++; $display("[TB] FAIL release_state: got %0d expected IDLE", dut_a.state_q); end
  endtask

  task automatic test_miss;
    int wl, fv;
    do_access(1'b0, 16'h0312, 1'b1, 16'h5A5A, 1'b0, 5, 0, wl, fv);
    total++; if (wl != 0) begin bad++; $display("[TB] FAIL miss_wait: got %0d expected 0", wl); end
    total++; if (fv != -1 || RdEn_a !== 1'b0) begin bad++; $display("[TB] FAIL miss_rden: got %0d/%b expected none/0", fv, RdEn_a); end
    release_bus(1'b0);
    do_access(1'b0, 16'h0012, 1'b1, 16'h0000, 1'b0, 5, 0, wl, fv);
    total++; if (RdData_a !== 16'hBEEF) begin bad++; $display("[TB] FAIL miss_mem_intact: got %h expected beef", RdData_a); end
    release_bus(1'b0);
  endtask

  task automatic test_abort;
    int wl, fv;
    do_access(1'b0, 16'h0012, 1'b0, 16'hDEAD, 1'b1, 3, 1, wl, fv);
    total++; if (wl != 1) begin bad++; $display("[TB] FAIL abort_wait: got %0d expected 1", wl); end
    total++; if (nWait_a !== 1'b1) begin bad++; $display("[TB] FAIL abort_nwait: got %b expected 1", nWait_a); end
    total++; if (dut_a.state_q !== IDLE) begin bad++; $display("[TB] FAIL abort_state: got %0d expected IDLE", dut_a.state_q); end
    do_access(1'b0, 16'h0012, 1'b1, 16'h0000, 1'b0, 5, 0, wl, fv);
    total++; if (RdData_a !== 16'hBEEF) begin bad++; $display("[TB] FAIL abort_no_write: got %h expected beef", RdData_a); end
    release_bus(1'b0);
  endtask

  task automatic test_noe_gating;
    int wl, fv;
    do_access(1'b0, 16'h0012, 1'b1, 16'h0000, 1'b0, 5, 0, wl, fv);
    total++; if (RdEn_a !== 1'b1) begin bad++; $display("[TB] FAIL noe_start: got %b expected 1", RdEn_a); end
    @(negedge Clock);
    nOE = 1'b1;
    #1;
    total++; if (RdEn_a !== 1'b0) begin bad++; $display("[TB] FAIL noe_high_rden: got %b expected 0", RdEn_a); end
    total++; if (RdData_a !== 16'hBEEF) begin bad++; $display("[TB] FAIL noe_high_data: got %h expected beef", RdData_a); end
    nOE = 1'b0;
    #1;
    total++; if (RdEn_a !== 1'b1 || RdData_a !== 16'hBEEF) begin bad++; $display("[TB] FAIL noe_low_again: got %b/%h expected 1/beef", RdEn_a, RdData_a); end
    release_bus(1'b0);
  endtask

  task automatic test_back_to_back;
    int wl, fv;
    do_access(1'b0, 16'h0013, 1'b0, 16'hCAFE, 1'b1, 5, 0, wl, fv);
    release_bus(1'b0);
    do_access(1'b0, 16'h0013, 1'b1, 16'h0000, 1'b0, 5, 0, wl, fv);
    total++; if (RdData_a !== 16'hCAFE || fv != 4) begin bad++; $display("[TB] FAIL b2b_first: got %h@%0d expected cafe@4", RdData_a, fv); end
    release_bus(1'b0);
    do_access(1'b0, 16'h0012, 1'b1, 16'h0000, 1'b0, 5, 0, wl, fv);
    total++; if (RdData_a !== 16'hBEEF || fv != 4) begin bad++; $display("[TB] FAIL b2b_second: got %h@%0d expected beef@4", RdData_a, fv); end
    release_bus(1'b0);
  endtask

  task automatic test_ws0;
    int wl, fv;
    do_access(1'b1, 16'h0020, 1'b0, 16'h1234, 1'b1, 3, 0, wl, fv);
    total++; if (wl != 0) begin bad++; $display("[TB] FAIL ws0_write_wait: got %0d expected 0", wl); end
    release_bus(1'b1);
    do_access(1'b1, 16'h0020, 1'b1, 16'h0000, 1'b0, 3, 0, wl, fv);
    total++; if (wl != 0) begin bad++; $display("[TB] FAIL ws0_read_wait: got %0d expected 0", wl); end
    total++; if (fv != 2) begin bad++; $display("[TB] FAIL ws0_latency: got %0d expected 2", fv); end
    total++; if (RdData_b !== 16'h1234) begin bad++; $display("[TB] FAIL ws0_data: got %h expected 1234", RdData_b); end
    release_bus(1'b1);
  endtask

  task automatic test_reset_mid_wait;
    int wl, fv;
    do_access(1'b0, 16'h0040, 1'b0, 16'h5555, 1'b1, 5, 0, wl, fv);
    release_bus(1'b0);
    do_access(1'b0, 16'h0040, 1'b0, 16'hAAAA, 1'b1, 1, 0, wl, fv);
    total++; if (nWait_a !== 1'b0) begin bad++; $display("[TB] FAIL midwait_pre: got %b expected 0", nWait_a); end
    #2;
    nReset = 1'b0;
    #1;
    total++; if (nWait_a !== 1'b1) begin bad++; $display("[TB] FAIL midwait_nwait: got %b expected 1", nWait_a); end
    total++; if (dut_a.state_q !== IDLE || RdEn_a !== 1'b0) begin bad++; $display("[TB] FAIL midwait_state: got %0d/%b expected IDLE/0", dut_a.state_q, RdEn_a); end
    nME_a = 1'b1;
    nOE = 1'b1;
    @(negedge Clock);
    nReset = 1'b1;
    do_access(1'b0, 16'h0040, 1'b1, 16'h0000, 1'b0, 5, 0, wl, fv);
    total++; if (RdData_a !== 16'h5555) begin bad++; $display("[TB] FAIL midwait_write_lost: got %h expected 5555", RdData_a); end
    release_bus(1'b0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_miss();
    test_abort();
    test_noe_gating();
    test_back_to_back();
    test_ws0();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
